// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Same-cycle load data on a hit; on a miss the pipeline stalls while a word-serial writeback and refill run.
module l1_dcache #(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_REFILL    = 2'd2;

  logic [31:0]          data_r [NUM_LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0]     tag_r  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_r;
  logic [NUM_LINES-1:0] dirty_r;

  logic [1:0]       state_r;
  logic [OFF_W-1:0] beat_r;
  logic [TAG_W-1:0] miss_tag_r;
  logic [IDX_W-1:0] miss_idx_r;
  logic [31:0]      hit_count_r;
  logic [31:0]      miss_count_r;

  logic [OFF_W-1:0] off_s;
  logic [IDX_W-1:0] idx_s;
  logic [TAG_W-1:0] tag_s;
  logic [TAG_W-1:0] victim_tag_s;
  logic             req_s;
  logic             hit_s;
  logic             last_beat_s;
  logic             unused_addr_bits_s;

  assign off_s              = cpu_addr[OFF_W+1:2];
  assign idx_s              = cpu_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign tag_s              = cpu_addr[ADDR_WIDTH-1:IDX_W+OFF_W+2];
  assign unused_addr_bits_s = ^cpu_addr[1:0];
  assign req_s              = cpu_read | cpu_write;
  assign victim_tag_s       = tag_r[miss_idx_r];
  assign last_beat_s        = (beat_r == OFF_W'(WORDS_PER_LINE - 1));
  // Valid is cleared at miss start, so a partially refilled line can never hit.
  assign hit_s              = (state_r == ST_IDLE) & valid_r[idx_s] & (tag_r[idx_s] == tag_s);
  assign cpu_stall          = req_s & ~hit_s;
  assign hit_count          = hit_count_r;
  assign miss_count         = miss_count_r;

  // Load data path: a simultaneous write wins, so only a pure read returns data.
  always_comb begin
    cpu_rdata = 32'b0;
    if (cpu_read & ~cpu_write & hit_s) begin
      cpu_rdata = data_r[{idx_s, off_s}];
    end else begin
      cpu_rdata = 32'b0;
    end
  end

  // Memory-side beat decode; address and data only move after an ack advances beat_r.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_WIDTH{1'b0}};
    mem_wdata = 32'b0;
    case (state_r)
      ST_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {victim_tag_s, miss_idx_r, beat_r, 2'b00};
        mem_wdata = data_r[{miss_idx_r, beat_r}];
      end
      ST_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag_r, miss_idx_r, beat_r, 2'b00};
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // Control FSM, line status bits and statistics counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      beat_r       <= {OFF_W{1'b0}};
      valid_r      <= {NUM_LINES{1'b0}};
      dirty_r      <= {NUM_LINES{1'b0}};
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hit_s) begin
            hit_count_r <= hit_count_r + 32'd1;
            if (cpu_write) dirty_r[idx_s] <= 1'b1;
          end else if (req_s) begin
            miss_count_r   <= miss_count_r + 32'd1;
            miss_tag_r     <= tag_s;
            miss_idx_r     <= idx_s;
            valid_r[idx_s] <= 1'b0;
            beat_r         <= {OFF_W{1'b0}};
            state_r        <= (valid_r[idx_s] & dirty_r[idx_s]) ? ST_WRITEBACK : ST_REFILL;
          end
        end
        ST_WRITEBACK: begin
          if (mem_ack) begin
            beat_r <= beat_r + OFF_W'(1);
            if (last_beat_s) begin
              dirty_r[miss_idx_r] <= 1'b0;
              state_r             <= ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          if (mem_ack) begin
            beat_r <= beat_r + OFF_W'(1);
            if (last_beat_s) begin
              valid_r[miss_idx_r] <= 1'b1;
              dirty_r[miss_idx_r] <= 1'b0;
              state_r             <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Data and tag arrays: store hits and refill beats; deliberately not reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (hit_s && cpu_write) begin
        data_r[{idx_s, off_s}] <= cpu_wdata;
      end
      if (state_r == ST_REFILL && mem_ack) begin
        data_r[{miss_idx_r, beat_r}] <= mem_rdata;
        if (last_beat_s) tag_r[miss_idx_r] <= miss_tag_r;
      end
    end
  end

endmodule
